// File: rtl/isa_pkg.sv
// Shared MIPS decode definitions for the front end: opcode constants, the
// instruction class enum and the split-field record buffered by the split stage.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        ITYPE_R = 2'd0,
        ITYPE_I = 2'd1,
        ITYPE_J = 2'd2
    } itype_t;

    // Number of held entries in the split stage buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // imm_lo is the immediate extended to 32 bits; imm_fill is the bit that
    // replicates into any positions above bit 31 when XLEN is wider.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func;
        logic [31:0] imm_lo;
        logic        imm_fill;
        logic [25:0] target;
        itype_t      itype;
    } split_fields_t;

endpackage

// File: rtl/split_fields.sv
// Combinational MIPS field extraction, classification and immediate extension.
module split_fields
    import isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]   instruction,
    output split_fields_t fields
);

    logic [5:0]  w_op;
    logic [15:0] w_imm16;
    logic        w_fill;

    assign w_op    = instruction[31:26];
    assign w_imm16 = instruction[15:0];

    always_comb begin
        fields        = '0;
        w_fill        = 1'b0;
        fields.opcode = w_op;
        fields.rs     = instruction[25:21];
        fields.rt     = instruction[20:16];
        fields.rd     = instruction[15:11];
        fields.shamt  = instruction[10:6];
        fields.func   = instruction[5:0];
        fields.target = instruction[25:0];

        if (w_op == OP_RTYPE) begin
            fields.itype = ITYPE_R;
        end else if (w_op == OP_J || w_op == OP_JAL) begin
            fields.itype = ITYPE_J;
        end else begin
            fields.itype = ITYPE_I;
        end

        // Logical immediates and LUI never sign-extend.
        case (w_op)
            OP_ANDI, OP_ORI, OP_XORI: fields.imm_lo = {16'h0000, w_imm16};
            OP_LUI:                   fields.imm_lo = {w_imm16, 16'h0000};
            default: begin
                fields.imm_lo = {{16{w_imm16[15]}}, w_imm16};
                w_fill        = w_imm16[15];
            end
        endcase

        fields.imm_fill = (XLEN > 32) && w_fill;
    end

endmodule

// File: rtl/inst_split_stage.sv
// Registered instruction-split stage between fetch and register read: one-deep
// register (SKID=0) or two-entry skid buffer with a registered in_ready (SKID=1).
module inst_split_stage
    import isa_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      func,
    output logic [XLEN-1:0] imm,
    output logic [25:0]     target,
    output logic [1:0]      itype,
    output logic [1:0]      dbg_state
);

    // Handshake: a word moves on any rising edge where valid and ready are both
    // high on that side; flush suppresses the input transfer in its cycle.

    split_fields_t w_fields;
    split_fields_t r_head;
    split_fields_t r_tail;
    buf_state_t    r_state;
    buf_state_t    w_state_next;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          w_accept;
    logic          w_drain;
    logic          w_load_head_in;
    logic          w_load_head_tail;
    logic          w_load_tail;

    split_fields #(.XLEN(XLEN)) u_split (
        .instruction (instruction),
        .fields      (w_fields)
    );

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = r_in_ready && !rst;
        end else begin : g_single
            logic w_unused_in_ready;
            assign w_unused_in_ready = r_in_ready;
            assign in_ready = !rst && (!r_out_valid || out_ready);
        end
    endgenerate

    assign w_accept = in_valid && in_ready && !flush;
    assign w_drain  = r_out_valid && out_ready;

    // With SKID=0 in_ready forbids an accept in ONE unless it drains, so the
    // TWO path is unreachable there and the tail register goes unused.
    always_comb begin
        w_state_next     = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_tail = 1'b0;
        w_load_tail      = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_accept) begin
                    w_state_next   = BUF_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            BUF_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_head_in = 1'b1;
                end else if (w_accept) begin
                    w_state_next = BUF_TWO;
                    w_load_tail  = 1'b1;
                end else if (w_drain) begin
                    w_state_next = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (w_drain) begin
                    w_state_next     = BUF_ONE;
                    w_load_head_tail = 1'b1;
                end
            end
            default: w_state_next = BUF_EMPTY;
        endcase
        if (flush) begin
            w_state_next     = BUF_EMPTY;
            w_load_head_in   = 1'b0;
            w_load_head_tail = 1'b0;
            w_load_tail      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BUF_EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next != BUF_EMPTY);
            r_in_ready  <= (w_state_next != BUF_TWO);
            if (w_load_head_in) begin
                r_head <= w_fields;
            end else if (w_load_head_tail) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= w_fields;
            end
        end
    end

    generate
        if (XLEN > 32) begin : g_wide_imm
            assign imm = {{(XLEN-32){r_head.imm_fill}}, r_head.imm_lo};
        end else begin : g_narrow_imm
            logic w_unused_fill;
            assign w_unused_fill = r_head.imm_fill;
            assign imm = r_head.imm_lo;
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign opcode    = r_head.opcode;
    assign rs        = r_head.rs;
    assign rt        = r_head.rt;
    assign rd        = r_head.rd;
    assign shamt     = r_head.shamt;
    assign func      = r_head.func;
    assign target    = r_head.target;
    assign itype     = r_head.itype;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_inst_split_stage.sv
// Bench for inst_split_stage: a SKID=1/XLEN=32 and a SKID=0/XLEN=64 instance run
// the same directed and random sequence against a queue-based reference model.
module tb_inst_split_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_valid_a = 1'b0;
    logic        in_valid_b = 1'b0;
    logic [31:0] instruction_a = '0;
    logic [31:0] instruction_b = '0;

    logic        a_in_ready, a_out_valid;
    logic [5:0]  a_opcode, a_func;
    logic [4:0]  a_rs, a_rt, a_rd, a_shamt;
    logic [31:0] a_imm;
    logic [25:0] a_target;
    logic [1:0]  a_itype, a_dbg_state;

    logic        b_in_ready, b_out_valid;
    logic [5:0]  b_opcode, b_func;
    logic [4:0]  b_rs, b_rt, b_rd, b_shamt;
    logic [63:0] b_imm;
    logic [25:0] b_target;
    logic [1:0]  b_itype, b_dbg_state;

    inst_split_stage #(.XLEN(32), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_a), .in_ready(a_in_ready), .instruction(instruction_a),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .opcode(a_opcode), .rs(a_rs), .rt(a_rt), .rd(a_rd), .shamt(a_shamt),
        .func(a_func), .imm(a_imm), .target(a_target), .itype(a_itype),
        .dbg_state(a_dbg_state)
    );

    inst_split_stage #(.XLEN(64), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_b), .in_ready(b_in_ready), .instruction(instruction_b),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .opcode(b_opcode), .rs(b_rs), .rt(b_rt), .rd(b_rd), .shamt(b_shamt),
        .func(b_func), .imm(b_imm), .target(b_target), .itype(b_itype),
        .dbg_state(b_dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the ISA rules; immediate always built at 64 bits.
    function automatic logic [127:0] exp_fields(input logic [31:0] w, input int xl);
        logic [5:0]  op;
        logic [63:0] im;
        logic [1:0]  it;
        op = w[31:26];
        if (op == 6'h00) it = 2'd0;
        else if (op == 6'h02 || op == 6'h03) it = 2'd2;
        else it = 2'd1;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) im = {48'h0, w[15:0]};
        else if (op == 6'h0F) im = {32'h0, w[15:0], 16'h0};
        else im = {{48{w[15]}}, w[15:0]};
        if (xl == 32) im[63:32] = 32'h0;
        return {4'h0, op, w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], im, w[25:0], it};
    endfunction

    function automatic logic [127:0] obs_a();
        return {4'h0, a_opcode, a_rs, a_rt, a_rd, a_shamt, a_func, 32'h0, a_imm, a_target, a_itype};
    endfunction

    function automatic logic [127:0] obs_b();
        return {4'h0, b_opcode, b_rs, b_rt, b_rd, b_shamt, b_func, b_imm, b_target, b_itype};
    endfunction

    task automatic check_outputs();
        chk("a_out_valid", a_out_valid, exp_a_q.size() > 0);
        chk("b_out_valid", b_out_valid, exp_b_q.size() > 0);
        chk("a_held", a_dbg_state, exp_a_q.size());
        if (exp_a_q.size() > 0) chk("a_fields", obs_a(), exp_fields(exp_a_q[0], 32));
        if (exp_b_q.size() > 0) chk("b_fields", obs_b(), exp_fields(exp_b_q[0], 64));
    endtask

    // One clock: drive inputs, check the predicted in_ready, update the model, step.
    task automatic cycle(input logic iv_a, input logic [31:0] ins_a,
                         input logic iv_b, input logic [31:0] ins_b,
                         input logic ordy, input logic fl,
                         output logic acc_a, output logic acc_b,
                         output logic dr_a, output logic dr_b);
        logic ra, rb;
        in_valid_a = iv_a; instruction_a = ins_a;
        in_valid_b = iv_b; instruction_b = ins_b;
        out_ready = ordy; flush = fl;
        #1;
        ra = exp_a_q.size() < 2;
        rb = (exp_b_q.size() == 0) || ordy;
        chk("a_in_ready", a_in_ready, ra);
        chk("b_in_ready", b_in_ready, rb);
        out_ready = ~ordy;
        #1;
        chk("a_in_ready_vs_out_ready", a_in_ready, ra);
        out_ready = ordy;
        #1;
        acc_a = iv_a && ra && !fl;
        acc_b = iv_b && rb && !fl;
        dr_a  = (exp_a_q.size() > 0) && ordy && !fl;
        dr_b  = (exp_b_q.size() > 0) && ordy && !fl;
        if (fl) begin
            exp_a_q.delete();
            exp_b_q.delete();
        end else begin
            if (dr_a) void'(exp_a_q.pop_front());
            if (dr_b) void'(exp_b_q.pop_front());
            if (acc_a) exp_a_q.push_back(ins_a);
            if (acc_b) exp_b_q.push_back(ins_b);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int edges);
        rst = 1'b1; flush = 1'b0;
        in_valid_a = 1'b1; in_valid_b = 1'b1;
        instruction_a = $urandom(); instruction_b = $urandom();
        out_ready = 1'($urandom_range(0, 1));
        exp_a_q.delete();
        exp_b_q.delete();
        for (int e = 0; e < edges; e++) begin
            @(posedge clk);
            #1;
            chk("rst_a_in_ready", a_in_ready, 0);
            chk("rst_b_in_ready", b_in_ready, 0);
            chk("rst_a_out_valid", a_out_valid, 0);
            chk("rst_b_out_valid", b_out_valid, 0);
            chk("rst_a_fields", obs_a(), 0);
            chk("rst_b_fields", obs_b(), 0);
        end
        rst = 1'b0;
    endtask

    // Send one word to both instances with out_ready high.
    task automatic send1(input logic [31:0] w);
        logic aa, ab, da, db;
        cycle(1'b1, w, 1'b1, w, 1'b1, 1'b0, aa, ab, da, db);
    endtask

    logic [5:0]  ops[8] = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08};
    logic [31:0] words[8];

    initial begin
        logic aa, ab, da, db;
        int pa, pb, ra_cnt, rb_cnt, guard;
        logic [31:0] w;

        do_reset(2);

        // Directed decode cases, each visible one edge after acceptance.
        send1(32'h012A4020);
        chk("add_opcode", a_opcode, 6'h00);
        chk("add_rs", a_rs, 5'd9);
        chk("add_rt", a_rt, 5'd10);
        chk("add_rd", a_rd, 5'd8);
        chk("add_func", a_func, 6'h20);
        chk("add_itype", a_itype, 2'd0);
        chk("add_imm", a_imm, 32'h00004020);
        send1(32'h2128FFFF);
        chk("addi_itype", a_itype, 2'd1);
        chk("addi_imm", a_imm, 32'hFFFFFFFF);
        chk("addi_imm64", b_imm, 64'hFFFFFFFF_FFFFFFFF);
        send1(32'h3528FFFF);
        chk("ori_imm", a_imm, 32'h0000FFFF);
        chk("ori_imm64", b_imm, 64'h00000000_0000FFFF);
        send1(32'h3C081234);
        chk("lui_imm", a_imm, 32'h12340000);
        chk("lui_imm64", b_imm, 64'h00000000_12340000);
        send1(32'h08000010);
        chk("j_itype", a_itype, 2'd2);
        chk("j_target", a_target, 26'h0000010);
        send1(32'h0C000020);
        chk("jal_itype", b_itype, 2'd2);
        chk("jal_target", b_target, 26'h0000020);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, aa, ab, da, db);

        // Backpressure: 8 words, out_ready toggling 1,0,0,1.
        for (int i = 0; i < 8; i++) words[i] = $urandom();
        pa = 0; pb = 0; ra_cnt = 0; rb_cnt = 0; guard = 0;
        while ((ra_cnt < 8 || rb_cnt < 8) && guard < 80) begin
            cycle(pa < 8, words[pa % 8], pb < 8, words[pb % 8],
                  (guard % 4 == 0) || (guard % 4 == 3), 1'b0, aa, ab, da, db);
            if (aa) pa++;
            if (ab) pb++;
            if (da) ra_cnt++;
            if (db) rb_cnt++;
            guard++;
        end
        chk("bp_a_drained", ra_cnt, 8);
        chk("bp_b_drained", rb_cnt, 8);

        // Flush while holding two words with a word offered in the flush cycle.
        cycle(1'b1, 32'h11111111, 1'b1, 32'h11111111, 1'b0, 1'b0, aa, ab, da, db);
        cycle(1'b1, 32'h22222222, 1'b1, 32'h22222222, 1'b0, 1'b0, aa, ab, da, db);
        chk("pre_flush_held", a_dbg_state, 2);
        cycle(1'b1, 32'h33333333, 1'b1, 32'h33333333, 1'b0, 1'b1, aa, ab, da, db);
        chk("flush_a_out_valid", a_out_valid, 0);
        chk("flush_b_out_valid", b_out_valid, 0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, aa, ab, da, db);

        // Reset mid-stream, then the first word after reset must emerge intact.
        cycle(1'b1, 32'h44444444, 1'b1, 32'h44444444, 1'b0, 1'b0, aa, ab, da, db);
        cycle(1'b1, 32'h55555555, 1'b1, 32'h55555555, 1'b0, 1'b0, aa, ab, da, db);
        do_reset(1);
        send1(32'h2128FFFF);
        chk("post_rst_a_imm", a_imm, 32'hFFFFFFFF);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            w = $urandom();
            if ($urandom_range(0, 1) == 1) w[31:26] = ops[$urandom_range(0, 7)];
            cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 3) != 0), w,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
                  aa, ab, da, db);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, aa, ab, da, db);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
